// File: rtl/product_accumulator.sv
// product_accumulator
//   Sequential multiply-accumulate back end for the 4x4 array multiplier. Accepts COUNT 8-bit
//   unsigned products over a valid/ready handshake, sums them into an ACC_W-bit accumulator,
//   then presents the finished sum (plus a sticky overflow flag) over a second valid/ready
//   handshake. One bubble cycle on the input side per result.
//
// Parameters
//   ACC_W  accumulator/result width, 8..16
//   COUNT  products summed per result, 1..255
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   clear      synchronous abort: drop partial sum, zero acc_out, back to accumulating
//   in_valid   product is valid
//   in_ready   accumulator can accept a product (low while clear=1 or a result is held)
//   product    unsigned product from the multiplier
//   out_valid  acc_out holds a finished sum
//   out_ready  consumer takes the sum
//   acc_out    finished sum, stable while out_valid=1
//   overflow   a carry out of the accumulator occurred for the current result
//   busy       at least one product accepted for the current result
//
// Build option
//   SATURATE_EN  when defined, the accumulator clamps to 2^ACC_W-1 on carry instead of wrapping.

module product_accumulator #(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic             busy
);

  localparam logic [7:0] LastIdx = 8'(COUNT - 1);

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [7:0]       cnt_q;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic             last;

  // One extra bit so the carry out of the accumulator is visible.
  assign sum   = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, product};
  assign carry = sum[ACC_W];
  assign last  = (cnt_q == LastIdx);

`ifdef SATURATE_EN
  // Once clamped, max + p carries again for any p != 0, so the clamp sticks for the result.
  assign acc_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  // clear masks in_ready so a product presented alongside clear is never taken.
  assign in_ready  = (state_q == StAcc) & ~clear;
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q == StHold) | (cnt_q != 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StAcc;
      acc_q    <= '0;
      cnt_q    <= '0;
      acc_out  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      state_q  <= StAcc;
      acc_q    <= '0;
      cnt_q    <= '0;
      acc_out  <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (in_valid) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + 8'd1;
            if (carry) begin
              overflow <= 1'b1;
            end
            if (last) begin
              acc_out <= acc_next;
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
            state_q  <= StAcc;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: dut0 (ACC_W=12, COUNT=4) and dut1 (ACC_W=9, COUNT=3).
// A scoreboard queue per DUT holds expected {overflow, sum}; a monitor compares whenever a
// result is presented and pops on handshake or clear.

module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [7:0]  product   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        overflow  [2];
  logic        busy      [2];
  logic [11:0] acc_out0;
  logic [8:0]  acc_out1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: running sum as a plain integer
  int          m_sum [2];
  int          m_cnt [2];
  bit          m_ovf [2];
  logic [16:0] exp_q0 [$];
  logic [16:0] exp_q1 [$];
  bit          rand_rdy;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(12), .COUNT(4)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear[0]),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .product  (product[0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .acc_out  (acc_out0),
    .overflow (overflow[0]),
    .busy     (busy[0])
  );

  product_accumulator #(.ACC_W(9), .COUNT(3)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear[1]),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .product  (product[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .acc_out  (acc_out1),
    .overflow (overflow[1]),
    .busy     (busy[1])
  );

  function automatic int acc_w(int d);
    return (d == 0) ? 12 : 9;
  endfunction

  function automatic int count_of(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int acc_of(int d);
    return (d == 0) ? int'(acc_out0) : int'(acc_out1);
  endfunction

  function automatic int q_size(int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic chk(string name, int d, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0d, expected %0d", d, name, got, want);
    end
  endtask

  task automatic model_clear(int d);
    m_sum[d] = 0;
    m_cnt[d] = 0;
    m_ovf[d] = 1'b0;
  endtask

  task automatic q_flush(int d);
    if (d == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  // Add one accepted product; on the COUNT-th, queue the expected result.
  task automatic model_accept(int d, int p);
    int maxv;
    logic [16:0] e;
    maxv = (1 << acc_w(d)) - 1;
    m_sum[d] = m_sum[d] + p;
    if (m_sum[d] > maxv) begin
      m_ovf[d] = 1'b1;
`ifdef SATURATE_EN
      m_sum[d] = maxv;
`else
      m_sum[d] = m_sum[d] % (maxv + 1);
`endif
    end
    m_cnt[d]++;
    if (m_cnt[d] == count_of(d)) begin
      e = {m_ovf[d], 16'(m_sum[d])};
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      model_clear(d);
    end
  endtask

  // Advance to just after the next rising edge; optionally randomise out_ready.
  task automatic step(int d);
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready[d] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic gap(int d, int n);
    repeat (n) step(d);
  endtask

  // Present one product and hold it until accepted (bounded).
  task automatic send(int d, int p);
    bit done;
    done = 1'b0;
    in_valid[d] = 1'b1;
    product[d]  = 8'(p);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        done = 1'b1;
        model_accept(d, p);
      end
      step(d);
    end
    in_valid[d] = 1'b0;
    if (!done) chk("accept_timeout", d, 0, 1);
  endtask

  task automatic monitor();
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          if (out_valid[d]) begin
            if (q_size(d) == 0) begin
              chk("unexpected_result", d, 1, 0);
            end else begin
              e = (d == 0) ? exp_q0[0] : exp_q1[0];
              chk("acc_out", d, acc_of(d), int'(e[15:0]));
              chk("overflow", d, int'(overflow[d]), int'(e[16]));
              if (out_ready[d] || clear[d]) begin
                if (d == 0) void'(exp_q0.pop_front());
                else        void'(exp_q1.pop_front());
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rand_rdy = 1'b0;
    for (int d = 0; d < 2; d++) begin
      clear[d]     = 1'b0;
      in_valid[d]  = 1'b0;
      product[d]   = 8'd0;
      out_ready[d] = 1'b0;
      model_clear(d);
    end
    fork
      monitor();
    join_none

    #2;
    chk("rst out_valid", 0, int'(out_valid[0]), 0);
    chk("rst busy", 0, int'(busy[0]), 0);
    chk("rst acc_out", 1, acc_of(1), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", 0, int'(in_ready[0]), 1);
    chk("post-rst overflow", 0, int'(overflow[0]), 0);
    step(0);

    // Back-to-back sum, consumer always ready
    out_ready[0] = 1'b1;
    send(0, 15); send(0, 30); send(0, 45); send(0, 225);
    @(negedge clk);
    chk("sum out_valid", 0, int'(out_valid[0]), 1);
    chk("sum in_ready bubble", 0, int'(in_ready[0]), 0);
    chk("sum acc_out", 0, acc_of(0), 315);
    @(negedge clk);
    chk("sum out_valid drop", 0, int'(out_valid[0]), 0);
    chk("sum in_ready back", 0, int'(in_ready[0]), 1);
    step(0);

    // Idle gaps, consumer stalls for 5 cycles
    out_ready[0] = 1'b0;
    send(0, 9); send(0, 0); gap(0, 3); send(0, 144); send(0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold out_valid", 0, int'(out_valid[0]), 1);
      chk("hold in_ready", 0, int'(in_ready[0]), 0);
      chk("hold acc_out", 0, acc_of(0), 154);
    end
    step(0);
    out_ready[0] = 1'b1;
    gap(0, 2);

    // Abort with clear alongside a valid product
    send(0, 7); send(0, 8);
    @(negedge clk);
    chk("pre-clear busy", 0, int'(busy[0]), 1);
    step(0);
    in_valid[0] = 1'b1;
    product[0]  = 8'd50;
    clear[0]    = 1'b1;
    @(negedge clk);
    chk("clear in_ready", 0, int'(in_ready[0]), 0);
    step(0);
    clear[0]    = 1'b0;
    in_valid[0] = 1'b0;
    model_clear(0);
    @(negedge clk);
    chk("post-clear busy", 0, int'(busy[0]), 0);
    chk("post-clear acc_out", 0, acc_of(0), 0);
    step(0);
    for (int i = 0; i < 4; i++) send(0, 100);
    @(negedge clk);
    chk("abort sum", 0, acc_of(0), 400);
    step(0);

    // Async reset while a result is held
    out_ready[0] = 1'b0;
    send(0, 10); send(0, 20); send(0, 30); send(0, 40);
    @(negedge clk);
    chk("pre-rst out_valid", 0, int'(out_valid[0]), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    q_flush(0);
    model_clear(0);
    #1;
    chk("async rst out_valid", 0, int'(out_valid[0]), 0);
    chk("async rst busy", 0, int'(busy[0]), 0);
    chk("async rst overflow", 0, int'(overflow[0]), 0);
    chk("async rst acc_out", 0, acc_of(0), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    step(0);
    out_ready[0] = 1'b1;

    // Wrap / saturate on the narrow instance
    out_ready[1] = 1'b1;
    send(1, 225); send(1, 225); send(1, 225);
    @(negedge clk);
    chk("wrap out_valid", 1, int'(out_valid[1]), 1);
    chk("wrap overflow", 1, int'(overflow[1]), 1);
`ifdef SATURATE_EN
    chk("wrap acc_out", 1, acc_of(1), 511);
`else
    chk("wrap acc_out", 1, acc_of(1), 163);
`endif
    @(negedge clk);
    chk("overflow cleared", 1, int'(overflow[1]), 0);
    step(1);

    // Randomised traffic with stalls, gaps and aborts
    rand_rdy = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        int r;
        r = int'($urandom_range(0, 19));
        if (r == 0) begin
          clear[d] = 1'b1;
          model_clear(d);
          step(d);
          clear[d] = 1'b0;
        end else if (r < 4) begin
          gap(d, int'($urandom_range(1, 3)));
        end else if (d == 1 && r < 12) begin
          send(d, int'($urandom_range(150, 255)));
        end else begin
          send(d, int'($urandom_range(0, 255)));
        end
      end
    end

    rand_rdy     = 1'b0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    for (int i = 0; i < 50 && (q_size(0) + q_size(1)) != 0; i++) step(0);
    chk("drain dut0 queue", 0, q_size(0), 0);
    chk("drain dut1 queue", 1, q_size(1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
